// File: rtl/rv_mc_ctrl.sv
// Multi-cycle control FSM for the RV32I core: sequences fetch/decode/exec/mem/wb,
// handshakes with instruction and data memory, traps on faults and counts retirements.
module rv_mc_ctrl #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       opcode,
  input  logic             br_cond,
  input  logic             imem_ack,
  input  logic             dmem_ack,
  output logic             imem_req,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic             ir_we,
  output logic             pc_we,
  output logic             pc_sel,
  output logic             reg_we,
  output logic             alu_b_imm,
  output logic [1:0]       wb_sel,
  output logic             trap,
  output logic [1:0]       trap_cause,
  output logic [CNT_W-1:0] retired
);

  localparam logic [6:0] OpR      = 7'b0110011;
  localparam logic [6:0] OpI      = 7'b0010011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;

  localparam int unsigned    WaitW     = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [WaitW-1:0] WaitLast = WaitW'(TIMEOUT - 1);
  localparam bit             TimeoutEn = (TIMEOUT != 0);

  typedef enum logic [2:0] {
    StFetch,
    StDecode,
    StExec,
    StMem,
    StWb,
    StTrap
  } state_e;

  state_e           state_q, state_d;
  logic [WaitW-1:0] wait_q;
  logic             trap_q;
  logic [1:0]       cause_q, cause_d;
  logic [CNT_W-1:0] cnt_q;

  logic is_r, is_i, is_load, is_store, is_branch, is_jal, is_jalr, is_lui, is_auipc;
  logic is_legal, timed_out;

  assign is_r      = (opcode == OpR);
  assign is_i      = (opcode == OpI);
  assign is_load   = (opcode == OpLoad);
  assign is_store  = (opcode == OpStore);
  assign is_branch = (opcode == OpBranch);
  assign is_jal    = (opcode == OpJal);
  assign is_jalr   = (opcode == OpJalr);
  assign is_lui    = (opcode == OpLui);
  assign is_auipc  = (opcode == OpAuipc);
  assign is_legal  = is_r | is_i | is_load | is_store | is_branch | is_jal | is_jalr |
                     is_lui | is_auipc;

  // Last permitted wait cycle; an ack in this same cycle still wins.
  assign timed_out = TimeoutEn && (wait_q == WaitLast);

  always_comb begin
    state_d   = state_q;
    cause_d   = cause_q;
    imem_req  = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    pc_sel    = 1'b0;
    reg_we    = 1'b0;
    alu_b_imm = 1'b0;
    wb_sel    = 2'b00;
    if (!rst) begin
      case (state_q)
        StFetch: begin
          imem_req = 1'b1;
          if (imem_ack) begin
            ir_we   = 1'b1;
            state_d = StDecode;
          end else if (timed_out) begin
            state_d = StTrap;
            cause_d = 2'b10;
          end
        end
        StDecode: begin
          if (!is_legal) begin
            state_d = StTrap;
            cause_d = 2'b01;
          end else begin
            state_d = StExec;
          end
        end
        StExec: begin
          alu_b_imm = is_i | is_load | is_store | is_jalr | is_lui | is_auipc;
          if (is_branch) begin
            pc_we   = 1'b1;
            pc_sel  = br_cond;
            state_d = StFetch;
          end else if (is_load || is_store) begin
            state_d = StMem;
          end else begin
            state_d = StWb;
          end
        end
        StMem: begin
          dmem_req = 1'b1;
          dmem_we  = is_store;
          if (dmem_ack) begin
            if (is_store) begin
              pc_we   = 1'b1;
              state_d = StFetch;
            end else begin
              state_d = StWb;
            end
          end else if (timed_out) begin
            state_d = StTrap;
            cause_d = 2'b11;
          end
        end
        StWb: begin
          reg_we  = 1'b1;
          pc_we   = 1'b1;
          pc_sel  = is_jal | is_jalr;
          wb_sel  = is_load ? 2'b01 : ((is_jal | is_jalr) ? 2'b10 : 2'b00);
          state_d = StFetch;
        end
        default: state_d = StTrap;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StFetch;
      wait_q  <= '0;
      trap_q  <= 1'b0;
      cause_q <= 2'b00;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      if (state_d == StTrap) trap_q <= 1'b1;
      if (state_d != state_q) begin
        wait_q <= '0;
      end else if (state_q == StFetch || state_q == StMem) begin
        wait_q <= wait_q + WaitW'(1);
      end
      if (pc_we) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign trap       = trap_q & ~rst;
  assign trap_cause = rst ? 2'b00 : cause_q;
  assign retired    = rst ? '0 : cnt_q;

endmodule

// File: tb/tb_rv_mc_ctrl.sv
// Randomized scoreboard bench for rv_mc_ctrl: a per-instruction reference model predicts
// each commit or trap, and a negedge monitor checks the DUT against the queued predictions.
module tb_rv_mc_ctrl;

  localparam int unsigned TO = 4;
  localparam int unsigned CW = 4;

  localparam logic [6:0] OpR      = 7'b0110011;
  localparam logic [6:0] OpI      = 7'b0010011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [6:0]    opcode = '0;
  logic          br_cond = 1'b0;
  logic          imem_ack = 1'b0;
  logic          dmem_ack = 1'b0;
  logic          imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_sel, reg_we, alu_b_imm;
  logic [1:0]    wb_sel, trap_cause;
  logic          trap;
  logic [CW-1:0] retired;

  rv_mc_ctrl #(
    .TIMEOUT(TO),
    .CNT_W  (CW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .opcode    (opcode),
    .br_cond   (br_cond),
    .imem_ack  (imem_ack),
    .dmem_ack  (dmem_ack),
    .imem_req  (imem_req),
    .dmem_req  (dmem_req),
    .dmem_we   (dmem_we),
    .ir_we     (ir_we),
    .pc_we     (pc_we),
    .pc_sel    (pc_sel),
    .reg_we    (reg_we),
    .alu_b_imm (alu_b_imm),
    .wb_sel    (wb_sel),
    .trap      (trap),
    .trap_cause(trap_cause),
    .retired   (retired)
  );

  always #5 clk = ~clk;

  // One predicted outcome per instruction: either a commit (pc_we) or a trap.
  typedef struct {
    bit            is_trap;
    logic [1:0]    cause;
    logic          pc_sel;
    int            n_reg;
    logic [1:0]    wb;
    bit            imm;
    int            n_ir;
    int            n_ireq;
    int            n_dreq;
    bit            dwe;
    int            cycles;
    logic [CW-1:0] ret;
  } exp_t;

  exp_t          q[$];
  int            n_checks = 0;
  int            n_fail = 0;
  logic [CW-1:0] model_ret = '0;
  logic [6:0]    legal_ops[9] = '{OpR, OpI, OpLoad, OpStore, OpBranch, OpJal, OpJalr,
                                  OpLui, OpAuipc};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic bound_fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: actual=bound expired required=handshake at %0t", name, $time);
  endtask

  // Cycle counts and strobe footprints follow directly from the opcode class table.
  function automatic exp_t predict(input logic [6:0] op, input int idel, input int ddel,
                                   input logic brc);
    exp_t e;
    e = '{default: 0};
    e.n_ir   = 1;
    e.n_ireq = idel + 1;
    case (op)
      OpR:      begin e.cycles = 4; e.n_reg = 1; end
      OpI:      begin e.cycles = 4; e.n_reg = 1; e.imm = 1; end
      OpLui:    begin e.cycles = 4; e.n_reg = 1; e.imm = 1; end
      OpAuipc:  begin e.cycles = 4; e.n_reg = 1; e.imm = 1; end
      OpJal:    begin e.cycles = 4; e.n_reg = 1; e.wb = 2'b10; e.pc_sel = 1'b1; end
      OpJalr:   begin e.cycles = 4; e.n_reg = 1; e.wb = 2'b10; e.pc_sel = 1'b1; e.imm = 1; end
      OpBranch: begin e.cycles = 3; e.pc_sel = brc; end
      OpLoad:   begin
        e.cycles = 5 + ddel; e.n_reg = 1; e.wb = 2'b01; e.imm = 1; e.n_dreq = ddel + 1;
      end
      OpStore:  begin
        e.cycles = 4 + ddel; e.imm = 1; e.n_dreq = ddel + 1; e.dwe = 1;
      end
      default:  begin e.is_trap = 1; e.cause = 2'b01; e.cycles = 3; end
    endcase
    e.cycles += idel;
    return e;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [6:0] op, input int idel, input logic brc);
    int n = 0;
    int g = 0;
    while (!(imem_req && n == idel)) begin
      if (imem_req) n++;
      step();
      g++;
      if (g > 40) begin
        bound_fail("fetch_wait");
        return;
      end
    end
    imem_ack = 1'b1;
    opcode   = op;
    br_cond  = brc;
    step();
    imem_ack = 1'b0;
  endtask

  task automatic data(input int ddel);
    int n = 0;
    int g = 0;
    while (!(dmem_req && n == ddel)) begin
      if (dmem_req) n++;
      step();
      g++;
      if (g > 40) begin
        bound_fail("dmem_wait");
        return;
      end
    end
    dmem_ack = 1'b1;
    step();
    dmem_ack = 1'b0;
  endtask

  task automatic do_instr(input logic [6:0] op, input int idel, input int ddel,
                          input logic brc);
    exp_t e;
    e = predict(op, idel, ddel, brc);
    if (!e.is_trap) model_ret = model_ret + 1'b1;
    e.ret = model_ret;
    q.push_back(e);
    fetch(op, idel, brc);
    if (op == OpLoad || op == OpStore) data(ddel);
  endtask

  task automatic rand_instr();
    do_instr(legal_ops[$urandom_range(0, 8)], int'($urandom_range(0, 3)),
             int'($urandom_range(0, 3)), logic'($urandom_range(0, 1)));
  endtask

  task automatic do_reset(input int n);
    rst       = 1'b1;
    model_ret = '0;
    repeat (n) step();
    rst = 1'b0;
    #1;
  endtask

  task automatic drain();
    int g = 0;
    while (q.size() != 0 && g < 30) begin
      step();
      g++;
    end
    if (q.size() != 0) bound_fail("drain");
  endtask

  // Monitor: accumulates strobe activity per instruction window and checks on each event.
  int            cyc, w_ir, w_reg, w_ireq, w_dreq;
  bit            w_imm, w_dwe, in_trap, ret_pending;
  logic [1:0]    w_wb, held_cause;
  logic [CW-1:0] held_ret, ret_exp;

  task automatic clear_win();
    cyc = 0; w_ir = 0; w_reg = 0; w_ireq = 0; w_dreq = 0;
    w_imm = 0; w_dwe = 0; w_wb = 2'b00;
  endtask

  initial begin
    clear_win();
    in_trap = 0;
    ret_pending = 0;
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      chk("reset_outputs_zero",
          32'({imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_sel, reg_we, alu_b_imm,
               wb_sel, trap, trap_cause, retired}), 32'd0);
      clear_win();
      in_trap = 0;
      ret_pending = 0;
    end else if (in_trap) begin
      chk("trap_hold_flag", 32'(trap), 32'd1);
      chk("trap_hold_cause", 32'(trap_cause), 32'(held_cause));
      chk("trap_hold_strobes",
          32'({imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_sel, reg_we, alu_b_imm,
               wb_sel}), 32'd0);
      chk("trap_hold_retired", 32'(retired), 32'(held_ret));
    end else begin
      if (ret_pending) begin
        chk("retired_count", 32'(retired), 32'(ret_exp));
        ret_pending = 0;
      end
      cyc++;
      if (ir_we) w_ir++;
      if (imem_req) w_ireq++;
      if (dmem_req) w_dreq++;
      if (dmem_req && dmem_we) w_dwe = 1;
      if (alu_b_imm) w_imm = 1;
      if (reg_we) begin
        w_reg++;
        w_wb = wb_sel;
      end
      if (trap || pc_we) begin
        if (q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_event: actual trap=%0b pc_we=%0b required=none at %0t",
                   trap, pc_we, $time);
          clear_win();
        end else begin
          e = q.pop_front();
          chk("event_kind", 32'(trap), 32'(e.is_trap));
          chk("cycles", 32'(cyc), 32'(e.cycles));
          chk("ir_we_pulses", 32'(w_ir), 32'(e.n_ir));
          chk("imem_req_cycles", 32'(w_ireq), 32'(e.n_ireq));
          chk("dmem_req_cycles", 32'(w_dreq), 32'(e.n_dreq));
          chk("reg_we_pulses", 32'(w_reg), 32'(e.n_reg));
          chk("dmem_we_seen", 32'(w_dwe), 32'(e.dwe));
          if (trap) begin
            chk("trap_cause", 32'(trap_cause), 32'(e.cause));
            in_trap    = 1;
            held_cause = e.cause;
            held_ret   = e.ret;
          end else begin
            chk("pc_sel", 32'(pc_sel), 32'(e.pc_sel));
            chk("alu_b_imm_seen", 32'(w_imm), 32'(e.imm));
            if (e.n_reg != 0) chk("wb_sel", 32'(w_wb), 32'(e.wb));
            ret_pending = 1;
            ret_exp     = e.ret;
          end
          clear_win();
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual=time limit required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    do_reset(3);
    do_instr(OpR, 0, 0, 1'b0);
    do_instr(OpLoad, 0, 2, 1'b0);
    do_instr(OpBranch, 0, 0, 1'b1);
    do_instr(OpBranch, 1, 0, 1'b0);
    repeat (30) rand_instr();
    drain();

    // Counter wraps at 2^CW: the 17th retirement reads back as 1.
    do_reset(2);
    repeat (17) rand_instr();
    drain();

    // Reset while a load waits in MEM: no writeback, counter cleared.
    fetch(OpLoad, 0, 1'b0);
    begin
      int g = 0;
      while (!dmem_req && g < 10) begin
        step();
        g++;
      end
      if (!dmem_req) bound_fail("mem_entry");
    end
    step();
    rst = 1'b1;
    model_ret = '0;
    repeat (2) step();
    rst = 1'b0;
    #1;
    do_instr(OpR, 0, 0, 1'b0);
    do_instr(OpI, TO - 1, 0, 1'b0);
    drain();
    do_reset(2);

    // Illegal opcode traps two cycles after ir_we and holds.
    e = predict(7'b1111111, 1, 0, 1'b0);
    e.ret = model_ret;
    q.push_back(e);
    fetch(7'b1111111, 1, 1'b0);
    repeat (20) step();
    do_reset(2);

    // Instruction fetch never acknowledged.
    e = '{default: 0};
    e.is_trap = 1; e.cause = 2'b10; e.cycles = TO + 1; e.n_ireq = TO; e.ret = model_ret;
    q.push_back(e);
    repeat (20) step();
    do_reset(2);

    // Store whose data access is never acknowledged.
    do_instr(OpAuipc, 2, 0, 1'b0);
    e = '{default: 0};
    e.is_trap = 1; e.cause = 2'b11; e.cycles = TO + 4; e.n_ir = 1; e.n_ireq = 1;
    e.n_dreq = TO; e.dwe = 1; e.ret = model_ret;
    q.push_back(e);
    fetch(OpStore, 0, 1'b0);
    repeat (20) step();
    do_reset(2);

    chk("queue_empty", 32'(q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
